// File: rtl/dac_adc_pkg.sv
// Shared definitions for the ADC pair decimator.
// Contents: Q15 scale shift, output sample width, h[n] width, the signed
// sample type and the offset-binary to two's-complement conversion.
package dac_adc_pkg;
  localparam int Q15   = 15;
  localparam int OUT_W = 16;
  localparam int H_W   = 19;

  typedef logic signed [OUT_W-1:0] smp_t;

  // Offset binary -> two's complement is an MSB flip.
  function automatic smp_t ob2s(input logic [OUT_W-1:0] x);
    return {~x[OUT_W-1], x[OUT_W-2:0]};
  endfunction
endpackage

// File: rtl/adc_pair_decim_if.sv
// Sample/result bus of adc_pair_decim.
//   in0, in1 : earlier / later ADC sample of a pair, offset binary
//   k        : decimation exponent (N = 2^k)
//   out_data : signed decimated result, held between strobes
//   out_stb  : one-cycle "out_data is new" pulse
//   ovf      : sticky saturation flag
// master = sample source, slave = decimator.
interface adc_pair_decim_if;
  import dac_adc_pkg::*;
  logic [OUT_W-1:0] in0;
  logic [OUT_W-1:0] in1;
  logic [3:0]       k;
  smp_t             out_data;
  logic             out_stb;
  logic             ovf;

  modport master (output in0, in1, k, input out_data, out_stb, ovf);
  modport slave  (input in0, in1, k, output out_data, out_stb, ovf);
endinterface

// File: rtl/adc_pair_hb.sv
// Three-tap half-band stage: converts each pair to signed, delays one pair
// and forms h[n] = floor((o[n]*2^14 + (e[n]+e[n+1])*COEFF) / 2^15).
//   clk, rst : clock, synchronous active-high reset
//   in0, in1 : raw offset-binary pair, one per clock
//   h, h_vld : 19-bit signed tap output and its valid
// h_vld rises only once h is built from two real pairs after reset.
module adc_pair_hb
  import dac_adc_pkg::*;
#(
  parameter logic signed [17:0] COEFF = 18'sd8192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OUT_W-1:0]      in0,
  input  logic [OUT_W-1:0]      in1,
  output logic signed [H_W-1:0] h,
  output logic                  h_vld
);
  localparam int STAGES = 3;

  logic [STAGES:0]    vld_pipe;
  smp_t               e_cur, o_cur, e_prv, o_prv;
  logic signed [16:0] side;
  logic signed [35:0] p_c, p_s, h_full;

  // e_prv/o_prv hold pair n, e_cur holds pair n+1.
  assign side   = 17'(e_prv) + 17'(e_cur);
  assign h_full = p_c + p_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      e_cur    <= '0;
      o_cur    <= '0;
      e_prv    <= '0;
      o_prv    <= '0;
      p_c      <= '0;
      p_s      <= '0;
      h        <= '0;
    end else begin
      // One extra shift stage covers the second pair h[n] needs, so
      // vld_pipe[STAGES] marks the first h made from two real pairs.
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      e_cur    <= ob2s(in0);
      o_cur    <= ob2s(in1);
      e_prv    <= e_cur;
      o_prv    <= o_cur;
      p_c      <= 36'(o_prv) * 36'sd16384;
      p_s      <= 36'(side) * 36'(COEFF);
      h        <= H_W'(h_full >>> Q15);
    end
  end

  assign h_vld = vld_pipe[STAGES];
endmodule

// File: rtl/adc_pair_decim.sv
// ADC pair decimator: half-band tap (adc_pair_hb) followed by an N = 2^k
// block accumulator, arithmetic >>> k and saturation to 16 bits.
//   clk, rst : clock, synchronous active-high reset
//   bus      : adc_pair_decim_if.slave (in0, in1, k, out_data, out_stb, ovf)
// Optional macro ADC_PAIR_DECIM_OVF_EN: sticky ovf on any output saturation;
// without it ovf is tied low.
// Latency (k=0): out_stb 4 edges after the edge that samples pair n+1.
module adc_pair_decim
  import dac_adc_pkg::*;
#(
  parameter logic signed [17:0] COEFF = 18'sd8192,
  parameter int                 KMAX  = 8
) (
  input logic             clk,
  input logic             rst,
  adc_pair_decim_if.slave bus
);
  localparam int                     AW    = H_W + KMAX;
  localparam logic [3:0]             KMAX4 = 4'(KMAX);
  localparam logic signed [AW-1:0]   SMAX  = AW'(2**(OUT_W-1) - 1);
  localparam logic signed [AW-1:0]   SMIN  = AW'(-(2**(OUT_W-1)));
  localparam logic [KMAX:0]          CNT1  = {{KMAX{1'b0}}, 1'b1};

  logic signed [H_W-1:0] h;
  logic                  h_vld;

  adc_pair_hb #(.COEFF(COEFF)) u_hb (
    .clk   (clk),
    .rst   (rst),
    .in0   (bus.in0),
    .in1   (bus.in1),
    .h     (h),
    .h_vld (h_vld)
  );

  logic [KMAX:0]          cnt;
  logic [3:0]             k_clamp, k_use, k_blk, k_out;
  logic signed [AW-1:0]   acc, acc_base, acc_nxt, shifted;
  logic                   blk_end, done_q;
  smp_t                   sat_val, out_q;
  logic                   stb_q;

  always_comb begin
    k_clamp  = (bus.k > KMAX4) ? KMAX4 : bus.k;
    // k is taken from the port only on the first h of a block; the rest of
    // the block runs on the latched copy.
    k_use    = (cnt == '0) ? k_clamp : k_blk;
    acc_base = (cnt == '0) ? '0 : acc;
    acc_nxt  = acc_base + AW'(h);
    blk_end  = (cnt == (KMAX+1)'((1 << k_use) - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      k_blk  <= '0;
      k_out  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= h_vld && blk_end;
      if (h_vld) begin
        acc <= acc_nxt;
        if (cnt == '0) k_blk <= k_clamp;
        if (blk_end) begin
          cnt   <= '0;
          k_out <= k_use;
        end else begin
          cnt <= cnt + CNT1;
        end
      end
    end
  end

  // acc holds the finished block sum for the cycle done_q is high.
  assign shifted = acc >>> k_out;

  always_comb begin
    if (shifted > SMAX)      sat_val = 16'sh7FFF;
    else if (shifted < SMIN) sat_val = 16'sh8000;
    else                     sat_val = OUT_W'(shifted);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      stb_q <= 1'b0;
    end else begin
      stb_q <= done_q;
      if (done_q) out_q <= sat_val;
    end
  end

  assign bus.out_data = out_q;
  assign bus.out_stb  = stb_q;

`ifdef ADC_PAIR_DECIM_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst)                                              ovf_q <= 1'b0;
    else if (done_q && (shifted > SMAX || shifted < SMIN)) ovf_q <= 1'b1;
  end
  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_adc_pair_decim.sv
// Bench for adc_pair_decim. dut_a (default COEFF) is checked every cycle
// against a cycle-accurate scoreboard built from the arithmetic definition;
// dut_b (COEFF=32767) covers saturation and the ovf flag.
module tb_adc_pair_decim;
  localparam longint COEFF_A = 8192;
`ifdef ADC_PAIR_DECIM_OVF_EN
  localparam int OVF_EN = 1;
`else
  localparam int OVF_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in0, d_in1;
  logic [3:0]  d_k;

  always #5 clk = ~clk;

  adc_pair_decim_if bus_a ();
  adc_pair_decim_if bus_b ();
  assign bus_a.in0 = d_in0;
  assign bus_a.in1 = d_in1;
  assign bus_a.k   = d_k;
  assign bus_b.in0 = d_in0;
  assign bus_b.in1 = d_in1;
  assign bus_b.k   = d_k;

  adc_pair_decim dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  adc_pair_decim #(.COEFF(18'sd32767)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {int cyc; int val; bit sat;} exp_t;

  int     cyc, nvec, nmis;
  exp_t   expq[$];
  int     stb_cyc[$];
  bit     last_stb;
  int     last_exp, exp_ovf;
  // reference model state
  bit     have_prev;
  longint pe, po, sum;
  int     cnt, bk;

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && ((a < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    nvec++;
    assert (got === want)
    else begin
      nmis++;
      $error("FAIL %s cyc=%0d got %0d want %0d", tag, cyc, got, want);
    end
  endtask

  // Apply one pair across one clock edge, advance the model, check dut_a.
  task automatic step(input bit r, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] kk);
    longint e, o, h, v;
    bit     s, exp_stb;
    rst = r; d_in0 = a; d_in1 = b; d_k = kk;
    @(posedge clk);
    cyc++;
    if (r) begin
      have_prev = 0; cnt = 0; sum = 0; expq.delete();
      last_exp = 0; exp_ovf = 0;
    end else begin
      e = longint'(a) - 32768;
      o = longint'(b) - 32768;
      if (have_prev) begin
        h = fdiv(po * 16384 + (pe + e) * COEFF_A, 32768);
        if (cnt == 0) bk = (kk > 8) ? 8 : int'(kk);
        sum += h;
        cnt++;
        if (cnt == (1 << bk)) begin
          v = fdiv(sum, longint'(1) << bk);
          s = (v > 32767) || (v < -32768);
          if (v > 32767) v = 32767;
          if (v < -32768) v = -32768;
          expq.push_back('{cyc + 4, int'(v), s});
          cnt = 0; sum = 0;
        end
      end
      pe = e; po = o; have_prev = 1;
    end
    #1;
    exp_stb = (expq.size() > 0) && (expq[0].cyc == cyc);
    chk("stb", int'(bus_a.out_stb), int'(exp_stb));
    if (exp_stb) begin
      last_exp = expq[0].val;
      if (expq[0].sat && OVF_EN == 1) exp_ovf = 1;
      void'(expq.pop_front());
      chk("data", int'(bus_a.out_data), last_exp);
    end else begin
      chk("hold", int'(bus_a.out_data), last_exp);
    end
    chk("ovf", int'(bus_a.ovf), exp_ovf);
    last_stb = bus_a.out_stb;
    if (bus_a.out_stb) stb_cyc.push_back(cyc);
  endtask

  task automatic run(input int n, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] kk);
    for (int i = 0; i < n; i++) step(0, a, b, kk);
  endtask

  task automatic wait_stb(input logic [15:0] a, input logic [3:0] kk, input int lim);
    int i;
    i = 0;
    step(0, a, a, kk);
    while (!last_stb && i < lim) begin
      step(0, a, a, kk);
      i++;
    end
    if (!last_stb) chk("wait_stb", 0, 1);
  endtask

  initial begin
    int mark, rcyc, rel, kk, n;
    int ks[4];
    cyc = 0; nvec = 0; nmis = 0; last_stb = 0;
    ks = '{0, 2, 5, 9};

    // reset state
    for (int i = 0; i < 3; i++) step(1, 16'h8000, 16'h8000, 0);
    chk("rst_b_data", int'(bus_b.out_data), 0);
    chk("rst_b_ovf", int'(bus_b.ovf), 0);

    // mid-scale input -> zero
    run(12, 16'h8000, 16'h8000, 0);
    chk("zero_data", int'(bus_a.out_data), 0);

    // quarter scale, first strobe 4 edges after the second real pair
    step(1, 16'hC000, 16'hC000, 0);
    stb_cyc.delete();
    rel = cyc + 1;
    run(12, 16'hC000, 16'hC000, 0);
    chk("first_stb", (stb_cyc.size() > 0) ? stb_cyc[0] : -1, rel + 5);
    chk("q_data", int'(bus_a.out_data), 16384);

    // floor of -0.5
    step(1, 16'h8000, 16'h8000, 0);
    run(10, 16'hFFFF, 16'h0000, 0);
    chk("neg_half", int'(bus_a.out_data), -1);

    // k=3 then k=1 mid-block
    step(1, 16'hC000, 16'hC000, 3);
    stb_cyc.delete();
    run(30, 16'hC000, 16'hC000, 3);
    wait_stb(16'hC000, 3, 12);
    mark = stb_cyc.size();
    run(2, 16'hC000, 16'hC000, 3);
    run(20, 16'hC000, 16'hC000, 1);
    if (mark >= 2 && stb_cyc.size() >= mark + 3) begin
      chk("k3_gap", stb_cyc[1] - stb_cyc[0], 8);
      chk("k_old_gap", stb_cyc[mark] - stb_cyc[mark-1], 8);
      chk("k_new_gap", stb_cyc[mark+1] - stb_cyc[mark], 2);
      chk("k_new_gap2", stb_cyc[mark+2] - stb_cyc[mark+1], 2);
    end else begin
      chk("k_stb_count", stb_cyc.size(), mark + 3);
    end
    chk("k_data", int'(bus_a.out_data), 16384);

    // reset mid-block discards the partial block
    step(1, 16'hC000, 16'hC000, 3);
    wait_stb(16'hC000, 3, 20);
    run(4, 16'hC000, 16'hC000, 3);
    step(1, 16'hC000, 16'hC000, 3);
    rcyc = cyc;
    stb_cyc.delete();
    run(20, 16'hC000, 16'hC000, 3);
    chk("rst_gap", (stb_cyc.size() > 0 && stb_cyc[0] - rcyc >= 12) ? 1 : 0, 1);
    chk("rst_data", int'(bus_a.out_data), 16384);

    // saturation on dut_b, ovf sticky when enabled
    step(1, 16'h8000, 16'h8000, 0);
    chk("b_ovf_clr", int'(bus_b.ovf), 0);
    run(10, 16'hFFFF, 16'hFFFF, 0);
    chk("b_sat", int'(bus_b.out_data), 32767);
    chk("b_ovf", int'(bus_b.ovf), OVF_EN);
    run(10, 16'h8000, 16'h8000, 0);
    chk("b_zero", int'(bus_b.out_data), 0);
    chk("b_ovf_hold", int'(bus_b.ovf), OVF_EN);

    // random data, several block sizes (9 clamps to 8)
    for (int p = 0; p < 4; p++) begin
      kk = ks[p];
      n = 20 + 3 * (1 << ((kk > 8) ? 8 : kk));
      step(1, 16'h8000, 16'h8000, 4'(kk));
      for (int i = 0; i < n; i++)
        step(0, 16'($urandom), 16'($urandom), 4'(kk));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
